// File: rtl/mmio_bus_bridge_if.sv
// Bus bundle between the Hack CPU data port, block RAM and the I/O channels.
// slave: bridge side (takes CPU/RAM/IO inputs, drives strobes); master: environment side.
interface mmio_bus_bridge_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_IO   = 4,
    parameter int IO_OFS_W = 4
);
    logic [14:0]            cpu_addr;
    logic [DATA_W-1:0]      cpu_wdata;
    logic                   cpu_wr;
    logic                   cpu_rd;
    logic [DATA_W-1:0]      cpu_rdata;
    logic                   cpu_stall;

    logic [13:0]            ram_addr;
    logic [DATA_W-1:0]      ram_wdata;
    logic                   ram_we;
    logic                   ram_re;
    logic [DATA_W-1:0]      ram_rdata;

    logic [NUM_IO-1:0]        io_sel;
    logic [IO_OFS_W-1:0]      io_addr;
    logic [DATA_W-1:0]        io_wdata;
    logic                     io_we;
    logic                     io_re;
    logic [NUM_IO*DATA_W-1:0] io_rdata;
    logic [NUM_IO-1:0]        io_ack;

    logic                   timeout_pulse;
    logic [7:0]             timeout_cnt;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wr, cpu_rd,
        output cpu_rdata, cpu_stall,
        output ram_addr, ram_wdata, ram_we, ram_re,
        input  ram_rdata,
        output io_sel, io_addr, io_wdata, io_we, io_re,
        input  io_rdata, io_ack,
        output timeout_pulse, timeout_cnt
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_wr, cpu_rd,
        input  cpu_rdata, cpu_stall,
        input  ram_addr, ram_wdata, ram_we, ram_re,
        output ram_rdata,
        input  io_sel, io_addr, io_wdata, io_we, io_re,
        output io_rdata, io_ack,
        input  timeout_pulse, timeout_cnt
    );
endinterface

// File: rtl/mmio_bus_bridge.sv
// Stall-capable Hack memory/I-O bridge: sync RAM with read latency, req/ack I/O, timeouts.
// Ports: clk, rst_n (async active-low), bus (mmio_bus_bridge_if.slave: cpu_*, ram_*, io_*, timeout_*).
module mmio_bus_bridge #(
    parameter int DATA_W     = 16,
    parameter int RAM_RD_LAT = 1,
    parameter int NUM_IO     = 4,
    parameter int IO_OFS_W   = 4,
    parameter int IO_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mmio_bus_bridge_if.slave     bus
);
    localparam int CH_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam logic [CH_W:0] NUM_IO_L = (CH_W+1)'(NUM_IO);

    typedef enum logic [1:0] {
        IDLE,
        RAM_WAIT,
        IO_WAIT,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          lat_q, lat_d;
    logic [7:0]          wait_q, wait_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [IO_OFS_W-1:0] ofs_q, ofs_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic                we_q, we_d;
    logic                re_q, re_d;
    logic [7:0]          tcnt_q, tcnt_d;

    logic            req;
    logic            is_rd;
    logic            is_ram;
    logic            is_io;
    logic            io_map;
    logic [CH_W-1:0] ch_dec;

    // Gating with rst_n keeps the combinational IDLE strobes at their
    // reset values while reset is held, even with a request pending.
    assign req    = (bus.cpu_wr | bus.cpu_rd) & rst_n;
    assign is_rd  = bus.cpu_rd & ~bus.cpu_wr;
    assign is_ram = ~bus.cpu_addr[14];
    assign is_io  = (bus.cpu_addr[14:13] == 2'b11);
    assign ch_dec = (NUM_IO == 1) ? '0 : bus.cpu_addr[IO_OFS_W +: CH_W];
    assign io_map = is_io & ({1'b0, ch_dec} < NUM_IO_L);

    assign bus.ram_addr    = bus.cpu_addr[13:0];
    assign bus.ram_wdata   = bus.cpu_wdata;
    assign bus.timeout_cnt = tcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lat_q   <= '0;
            wait_q  <= '0;
            rdata_q <= '0;
            ch_q    <= '0;
            ofs_q   <= '0;
            wdat_q  <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            ch_q    <= ch_d;
            ofs_q   <= ofs_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
            re_q    <= re_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        ch_d    = ch_q;
        ofs_d   = ofs_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
        re_d    = re_q;
        tcnt_d  = tcnt_q;

        bus.cpu_rdata     = '0;
        bus.cpu_stall     = 1'b0;
        bus.ram_we        = 1'b0;
        bus.ram_re        = 1'b0;
        bus.io_sel        = '0;
        bus.io_addr       = '0;
        bus.io_wdata      = '0;
        bus.io_we         = 1'b0;
        bus.io_re         = 1'b0;
        bus.timeout_pulse = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (is_ram) begin
                        if (bus.cpu_wr) begin
                            bus.ram_we = 1'b1;
                        end else begin
                            bus.ram_re    = 1'b1;
                            bus.cpu_stall = 1'b1;
                            lat_d         = 3'(RAM_RD_LAT);
                            state_d       = RAM_WAIT;
                        end
                    end else if (io_map) begin
                        bus.io_sel[ch_dec] = 1'b1;
                        bus.io_addr   = bus.cpu_addr[IO_OFS_W-1:0];
                        bus.io_wdata  = bus.cpu_wdata;
                        bus.io_we     = bus.cpu_wr;
                        bus.io_re     = is_rd;
                        bus.cpu_stall = 1'b1;
                        wait_d        = '0;
                        ch_d          = ch_dec;
                        ofs_d         = bus.cpu_addr[IO_OFS_W-1:0];
                        wdat_d        = bus.cpu_wdata;
                        we_d          = bus.cpu_wr;
                        re_d          = is_rd;
                        state_d       = IO_WAIT;
                    end
                    // Screen and unmapped channels: read 0, write dropped.
                end
            end
            RAM_WAIT: begin
                bus.cpu_stall = 1'b1;
                lat_d         = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    rdata_d = bus.ram_rdata;
                    state_d = DONE;
                end
            end
            IO_WAIT: begin
                bus.cpu_stall    = 1'b1;
                bus.io_sel[ch_q] = 1'b1;
                bus.io_addr      = ofs_q;
                bus.io_wdata     = wdat_q;
                bus.io_we        = we_q;
                bus.io_re        = re_q;
                wait_d           = wait_q + 8'd1;
                // Ack is tested first so it wins over a same-cycle timeout.
                if (bus.io_ack[ch_q]) begin
                    if (re_q) begin
                        rdata_d = bus.io_rdata[int'(ch_q)*DATA_W +: DATA_W];
                    end
                    state_d = DONE;
                end else if (wait_q == 8'(IO_TIMEOUT - 1)) begin
                    rdata_d           = '0;
                    bus.timeout_pulse = 1'b1;
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.cpu_rdata = rdata_q;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Testbench for mmio_bus_bridge: table vectors, hand sequences, random traffic vs model.
// Ports: none; instantiates mmio_bus_bridge_if and the bridge with a behavioural RAM.
module tb_mmio_bus_bridge;
    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam int NIO = 3;
    localparam int OFS = 4;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   tout_exp = 0;
    logic [15:0] ref_mem [16384];

    always #5 clk = ~clk;

    mmio_bus_bridge_if #(.DATA_W(DW), .NUM_IO(NIO), .IO_OFS_W(OFS)) bus ();

    mmio_bus_bridge #(
        .DATA_W(DW), .RAM_RD_LAT(LAT), .NUM_IO(NIO),
        .IO_OFS_W(OFS), .IO_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    // Behavioural sync RAM: data is valid exactly LAT cycles after ram_re,
    // otherwise a poison value so off-by-one captures show up.
    logic [15:0] mem [16384];
    logic [15:0] pd [LAT];
    logic        pv [LAT] = '{default: 1'b0};

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        pd[0] <= mem[bus.ram_addr];
        pv[0] <= bus.ram_re;
        for (int i = 1; i < LAT; i++) begin
            pd[i] <= pd[i-1];
            pv[i] <= pv[i-1];
        end
    end
    assign bus.ram_rdata = pv[LAT-1] ? pd[LAT-1] : 16'hDEAD;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Spec-level model: region by address range, latency by rule.
    task automatic model(input logic [14:0] a, input logic wr, input logic rd,
                         input int ack_k, input logic [15:0] iod,
                         output int st, output logic [15:0] rdv, output logic crd,
                         output logic [2:0] sel, output logic we, output logic re,
                         output int pulse);
        int av, ch;
        av = int'(a);
        st = 0; rdv = '0; crd = rd && !wr; sel = '0; we = 0; re = 0; pulse = -1;
        if (av < 16384) begin
            if (wr) we = 1;
            else begin re = 1; st = LAT + 1; rdv = ref_mem[av]; end
        end else if (av >= 24576) begin
            ch = (av / (1 << OFS)) % 4;
            if (ch < NIO) begin
                sel = 3'(1 << ch);
                if (ack_k >= 1 && ack_k <= TMO) begin
                    st = ack_k + 1; rdv = iod;
                end else begin
                    st = TMO + 1; rdv = '0; pulse = TMO;
                end
            end
        end
    endtask

    task automatic access(input logic [14:0] a, input logic [15:0] wd,
                          input logic wr, input logic rd,
                          input int ack_k, input int bad_k, input logic [15:0] iod,
                          input int st, input logic [15:0] rdv, input logic crd,
                          input logic [2:0] sel, input logic we, input logic re,
                          input int pulse, input string nm);
        int ch, stalls, re_cnt, p_at, p_cnt;
        logic [2:0] sel0;
        logic [3:0] ofs0;
        logic we0, iowe0, iore0, sel_bad, done;
        logic [15:0] got;
        ch = (int'(a) / (1 << OFS)) % 4;
        bus.io_rdata = {16'hC2C2, 16'hC1C1, 16'hC0C0};
        if (a >= 15'h6000 && ch < NIO) bus.io_rdata[ch*DW +: DW] = iod;
        bus.cpu_addr = a; bus.cpu_wdata = wd; bus.cpu_wr = wr; bus.cpu_rd = rd;
        stalls = 0; re_cnt = 0; p_at = -1; p_cnt = 0; sel_bad = 0; done = 0;
        got = '0; sel0 = '0; ofs0 = '0; we0 = 0; iowe0 = 0; iore0 = 0;
        for (int n = 0; n < 100 && !done; n++) begin
            bus.io_ack = '0;
            if (n == ack_k && a >= 15'h6000 && ch < NIO) bus.io_ack[ch] = 1'b1;
            if (n == bad_k) bus.io_ack[0] = 1'b1;
            #1;
            if (n == 0) begin
                sel0 = bus.io_sel; ofs0 = bus.io_addr; we0 = bus.ram_we;
                iowe0 = bus.io_we; iore0 = bus.io_re;
            end
            re_cnt += int'(bus.ram_re);
            if (bus.timeout_pulse) begin
                p_cnt++;
                if (p_at < 0) p_at = n;
            end
            if (bus.cpu_stall) begin
                stalls++;
                if (bus.io_sel !== sel) sel_bad = 1;
                @(posedge clk); #1;
            end else begin
                got = bus.cpu_rdata;
                done = 1;
            end
        end
        @(posedge clk); #1;
        bus.cpu_wr = 0; bus.cpu_rd = 0; bus.io_ack = '0;
        if (pulse >= 0 && tout_exp < 255) tout_exp++;
        if (a < 15'h4000 && wr) ref_mem[a[13:0]] = wd;
        chk({nm, ".done"}, 32'(done), 32'd1);
        chk({nm, ".stall"}, stalls, st);
        chk({nm, ".ram_re"}, re_cnt, 32'(re));
        chk({nm, ".ram_we"}, 32'(we0), 32'(we));
        chk({nm, ".io_sel"}, 32'(sel0), 32'(sel));
        chk({nm, ".sel_held"}, 32'(sel_bad), 32'd0);
        chk({nm, ".pulses"}, p_cnt, (pulse >= 0) ? 1 : 0);
        if (pulse >= 0) chk({nm, ".pulse_at"}, p_at, pulse);
        if (crd) chk({nm, ".rdata"}, 32'(got), 32'(rdv));
        if (sel != 0) begin
            chk({nm, ".io_addr"}, 32'(ofs0), 32'(a[3:0]));
            chk({nm, ".io_dir"}, 32'({iowe0, iore0}), 32'({wr, rd & ~wr}));
        end
        chk({nm, ".tcnt"}, 32'(bus.timeout_cnt), tout_exp);
    endtask

    task automatic run_model(input logic [14:0] a, input logic [15:0] wd,
                             input logic wr, input logic rd, input int ack_k,
                             input int bad_k, input logic [15:0] iod, input string nm);
        int st, pulse;
        logic [15:0] rdv;
        logic crd, we, re;
        logic [2:0] sel;
        model(a, wr, rd, ack_k, iod, st, rdv, crd, sel, we, re, pulse);
        access(a, wd, wr, rd, ack_k, bad_k, iod, st, rdv, crd, sel, we, re, pulse, nm);
    endtask

    typedef struct {
        logic [14:0] a;
        logic [15:0] wd;
        logic        wr, rd;
        int          ack_k, bad_k;
        logic [15:0] iod;
        int          st;
        logic [15:0] rdv;
        logic        crd;
        logic [2:0]  sel;
        logic        we, re;
        int          pulse;
    } vec_t;

    vec_t v [15];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        addr      wdata   wr rd ack bad iod      st rdata   crd sel     we re pulse
        v[0]  = '{15'h0010, 16'hBEEF, 1, 0, -1, -1, 16'h0000, 0, 16'h0000, 0, 3'b000, 1, 0, -1};
        v[1]  = '{15'h0010, 16'h0000, 0, 1, -1, -1, 16'h0000, 3, 16'hBEEF, 1, 3'b000, 0, 1, -1};
        v[2]  = '{15'h4123, 16'h0000, 0, 1, -1, -1, 16'h0000, 0, 16'h0000, 1, 3'b000, 0, 0, -1};
        v[3]  = '{15'h5000, 16'h1111, 1, 0, -1, -1, 16'h0000, 0, 16'h0000, 0, 3'b000, 0, 0, -1};
        v[4]  = '{15'h6011, 16'h0000, 0, 1,  3, -1, 16'h1234, 4, 16'h1234, 1, 3'b010, 0, 0, -1};
        v[5]  = '{15'h6025, 16'h7777, 1, 0, -1, -1, 16'h0000, 16, 16'h0000, 0, 3'b100, 0, 0, 15};
        v[6]  = '{15'h6030, 16'h0000, 0, 1,  1, -1, 16'h0000, 0, 16'h0000, 1, 3'b000, 0, 0, -1};
        v[7]  = '{15'h603F, 16'h2222, 1, 0,  1, -1, 16'h0000, 0, 16'h0000, 0, 3'b000, 0, 0, -1};
        v[8]  = '{15'h6022, 16'h0000, 0, 1, 15, -1, 16'hABCD, 16, 16'hABCD, 1, 3'b100, 0, 0, -1};
        v[9]  = '{15'h6007, 16'h0000, 0, 1,  1, -1, 16'h0F0F, 2, 16'h0F0F, 1, 3'b001, 0, 0, -1};
        v[10] = '{15'h0020, 16'h5A5A, 1, 1, -1, -1, 16'h0000, 0, 16'h0000, 0, 3'b000, 1, 0, -1};
        v[11] = '{15'h0020, 16'h0000, 0, 1, -1, -1, 16'h0000, 3, 16'h5A5A, 1, 3'b000, 0, 1, -1};
        v[12] = '{15'h601F, 16'h0000, 0, 1,  5,  2, 16'h4321, 6, 16'h4321, 1, 3'b010, 0, 0, -1};
        v[13] = '{15'h6021, 16'h0000, 0, 1, -1, -1, 16'h9999, 16, 16'h0000, 1, 3'b100, 0, 0, 15};
        v[14] = '{15'h6003, 16'h3333, 1, 1,  2, -1, 16'h0000, 3, 16'h0000, 0, 3'b001, 0, 0, -1};

        rst_n = 0;
        bus.cpu_addr = 15'h0005; bus.cpu_wdata = 16'h0; bus.cpu_wr = 1; bus.cpu_rd = 0;
        bus.io_ack = '0; bus.io_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.stall", 32'(bus.cpu_stall), 0);
        chk("rst.rdata", 32'(bus.cpu_rdata), 0);
        chk("rst.ram_we", 32'(bus.ram_we), 0);
        chk("rst.ram_re", 32'(bus.ram_re), 0);
        chk("rst.tpulse", 32'(bus.timeout_pulse), 0);
        chk("rst.tcnt", 32'(bus.timeout_cnt), 0);
        bus.cpu_addr = 15'h6011; bus.cpu_wr = 0; bus.cpu_rd = 1;
        #1;
        chk("rst.io_sel", 32'(bus.io_sel), 0);
        chk("rst.io_re", 32'(bus.io_re), 0);
        bus.cpu_rd = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            access(v[i].a, v[i].wd, v[i].wr, v[i].rd, v[i].ack_k, v[i].bad_k, v[i].iod,
                   v[i].st, v[i].rdv, v[i].crd, v[i].sel, v[i].we, v[i].re, v[i].pulse,
                   $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 32; i++) begin
            run_model(15'(i), 16'(i * 16'h0111 + 7), 1, 0, -1, -1, 16'h0, $sformatf("init%0d", i));
        end

        for (int i = 0; i < 150; i++) begin
            logic [14:0] a;
            int r, mode, bad;
            logic wr, rd;
            r = $urandom_range(0, 9);
            if (r < 4) a = 15'($urandom_range(0, 31));
            else if (r == 4) a = 15'(16'h4000 + $urandom_range(0, 16'h1FFF));
            else a = 15'(16'h6000 + $urandom_range(0, 16'h1FFF));
            mode = $urandom_range(0, 2);
            wr = (mode != 0);
            rd = (mode != 1);
            bad = (((int'(a) / (1 << OFS)) % 4) != 0) ? $urandom_range(1, 20) : -1;
            run_model(a, 16'($urandom), wr, rd, $urandom_range(1, 20), bad,
                      16'($urandom), $sformatf("rnd%0d", i));
        end

        for (int i = 0; i < 300; i++) begin
            run_model(15'(16'h6020 + (i % 16)), 16'(i), 1, 0, -1, -1, 16'h0,
                      $sformatf("sat%0d", i));
        end
        chk("sat.tcnt", 32'(bus.timeout_cnt), 255);

        bus.cpu_addr = 15'h0010; bus.cpu_rd = 1;
        @(posedge clk); #1;
        chk("rw.in_wait", 32'(bus.cpu_stall), 1);
        #2 rst_n = 0;
        #1;
        chk("rw.stall", 32'(bus.cpu_stall), 0);
        chk("rw.rdata", 32'(bus.cpu_rdata), 0);
        chk("rw.ram_re", 32'(bus.ram_re), 0);
        chk("rw.tcnt", 32'(bus.timeout_cnt), 0);
        tout_exp = 0;
        bus.cpu_rd = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        run_model(15'h0010, 16'h0, 0, 1, -1, -1, 16'h0, "rw.after");

        bus.cpu_addr = 15'h6011; bus.cpu_rd = 1;
        bus.io_ack = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("iw.sel", 32'(bus.io_sel), 32'(3'b010));
        #2 rst_n = 0;
        #1;
        chk("iw.io_sel", 32'(bus.io_sel), 0);
        chk("iw.io_re", 32'(bus.io_re), 0);
        chk("iw.stall", 32'(bus.cpu_stall), 0);
        bus.cpu_rd = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        chk("iw.no_done", 32'(bus.cpu_rdata), 0);
        run_model(15'h0011, 16'h0, 0, 1, -1, -1, 16'h0, "iw.after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
